// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle for the MIPS-lite multi-cycle sequencer.
// The master side is the controller; the slave side is the datapath/bench.
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             dm_ready;
  logic             PCWr;
  logic             IRWr;
  logic             RFWr;
  logic             DMWr;
  logic [2:0]       NPCOp;
  logic [1:0]       M1Sel;
  logic [1:0]       M2Sel;
  logic             M3Sel;
  logic [1:0]       EXTOp;
  logic [2:0]       ALUOp;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, funct, dm_ready,
    output PCWr, IRWr, RFWr, DMWr, NPCOp, M1Sel, M2Sel, M3Sel, EXTOp, ALUOp,
           state, illegal, instr_cnt
  );

  modport slave (
    output op, funct, dm_ready,
    input  PCWr, IRWr, RFWr, DMWr, NPCOp, M1Sel, M2Sel, M3Sel, EXTOp, ALUOp,
           state, illegal, instr_cnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-lite datapath: decodes op/funct into
// single-cycle select encodings and gates PC/IR/RF/DM writes per FSM state.
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multi_cycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB     = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic       is_lw_s, is_sw_s, is_br_s, is_jal_s, is_ill_s;
  logic [2:0] npc_op_s, alu_op_s;
  logic [1:0] m1_sel_s, m2_sel_s, ext_op_s;
  logic       m3_sel_s;
  logic       pcwr_s, irwr_s, rfwr_s, dmwr_s, illegal_s;

  // Instruction decode: class flags plus the single-cycle select encodings.
  always_comb begin
    is_lw_s  = 1'b0;
    is_sw_s  = 1'b0;
    is_br_s  = 1'b0;
    is_jal_s = 1'b0;
    is_ill_s = 1'b0;
    npc_op_s = 3'b000;
    m1_sel_s = 2'b00;
    m2_sel_s = 2'b00;
    m3_sel_s = 1'b0;
    ext_op_s = 2'b00;
    alu_op_s = 3'b000;
    case (bus.op)
      OP_RTYPE: begin
        case (bus.funct)
          FN_ADDU: m1_sel_s = 2'b01;
          FN_SUBU: begin
            m1_sel_s = 2'b01;
            alu_op_s = 3'b001;
          end
          FN_SLTU: begin
            m1_sel_s = 2'b01;
            alu_op_s = 3'b011;
          end
          FN_JR: begin
            is_br_s  = 1'b1;
            npc_op_s = 3'b011;
          end
          default: is_ill_s = 1'b1;
        endcase
      end
      OP_ORI: begin
        m3_sel_s = 1'b1;
        ext_op_s = 2'b01;
        alu_op_s = 3'b010;
      end
      OP_LW: begin
        is_lw_s  = 1'b1;
        m2_sel_s = 2'b01;
        m3_sel_s = 1'b1;
      end
      OP_SW: begin
        is_sw_s  = 1'b1;
        m3_sel_s = 1'b1;
      end
      OP_BEQ: begin
        is_br_s  = 1'b1;
        npc_op_s = 3'b001;
      end
      OP_LUI: begin
        m3_sel_s = 1'b1;
        ext_op_s = 2'b10;
      end
      OP_JAL: begin
        is_jal_s = 1'b1;
        npc_op_s = 3'b010;
        m1_sel_s = 2'b10;
        m2_sel_s = 2'b10;
      end
      default: is_ill_s = 1'b1;
    endcase
  end

  // Write enables; PCWr fires once, in the last state of each instruction.
  always_comb begin
    pcwr_s    = 1'b0;
    irwr_s    = 1'b0;
    rfwr_s    = 1'b0;
    dmwr_s    = 1'b0;
    illegal_s = 1'b0;
    if (reset) begin
      pcwr_s = 1'b0;
    end else begin
      case (state_q)
        FETCH:  irwr_s = 1'b1;
        DECODE: begin
          pcwr_s    = is_ill_s;
          illegal_s = is_ill_s;
        end
        EXEC:   pcwr_s = is_br_s;
        MEM_RD: pcwr_s = 1'b0;
        MEM_WR: begin
          dmwr_s = 1'b1;
          pcwr_s = bus.dm_ready;
        end
        WB: begin
          rfwr_s = 1'b1;
          pcwr_s = 1'b1;
        end
        default: pcwr_s = 1'b0;
      endcase
    end
  end

  // Next-state sequencing; unused codes fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (is_jal_s) begin
          state_d = WB;
        end else if (is_ill_s) begin
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_lw_s) begin
          state_d = MEM_RD;
        end else if (is_sw_s) begin
          state_d = MEM_WR;
        end else if (is_br_s) begin
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM_RD: state_d = bus.dm_ready ? WB : MEM_RD;
      MEM_WR: state_d = bus.dm_ready ? FETCH : MEM_WR;
      WB:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pcwr_s) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.PCWr      = pcwr_s;
  assign bus.IRWr      = irwr_s;
  assign bus.RFWr      = rfwr_s;
  assign bus.DMWr      = dmwr_s;
  assign bus.illegal   = illegal_s;
  assign bus.NPCOp     = npc_op_s;
  assign bus.M1Sel     = m1_sel_s;
  assign bus.M2Sel     = m2_sel_s;
  assign bus.M3Sel     = m3_sel_s;
  assign bus.EXTOp     = ext_op_s;
  assign bus.ALUOp     = alu_op_s;
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expectations are queued as
// stimulus is driven and popped/compared on the following falling edge.
module tb_multi_cycle_ctrl;

  typedef struct {
    logic [20:0] vec;
    logic [20:0] mask;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;
  logic [31:0] exp_cnt = 32'd0;
  exp_t  sb[$];
  string tag_q[$];

  multi_cycle_ctrl_if #(.CNT_W(32)) bus ();

  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_MR = 3'd3, S_MW = 3'd4, S_WB = 3'd5;
  // Enable vector order: {PCWr, IRWr, RFWr, DMWr, illegal}
  localparam logic [4:0] EN_0 = 5'b00000, EN_IR = 5'b01000, EN_WB = 5'b10100;
  localparam logic [4:0] EN_DM = 5'b00010, EN_DMPC = 5'b10010, EN_PC = 5'b10000, EN_ILL = 5'b10001;
  // Select vector order: {NPCOp, M1Sel, M2Sel, M3Sel, EXTOp, ALUOp}
  localparam logic [12:0] SL_ADDU = {3'b000, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [12:0] SL_SUBU = {3'b000, 2'b01, 2'b00, 1'b0, 2'b00, 3'b001};
  localparam logic [12:0] SL_SLTU = {3'b000, 2'b01, 2'b00, 1'b0, 2'b00, 3'b011};
  localparam logic [12:0] SL_ORI  = {3'b000, 2'b00, 2'b00, 1'b1, 2'b01, 3'b010};
  localparam logic [12:0] SL_LUI  = {3'b000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000};
  localparam logic [12:0] SL_LW   = {3'b000, 2'b00, 2'b01, 1'b1, 2'b00, 3'b000};
  localparam logic [12:0] SL_SW   = {3'b000, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000};
  localparam logic [12:0] SL_BEQ  = {3'b001, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [12:0] SL_JR   = {3'b011, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
  localparam logic [12:0] SL_JAL  = {3'b010, 2'b10, 2'b10, 1'b0, 2'b00, 3'b000};
  localparam logic [12:0] SL_NOP  = 13'd0;

  task automatic check();
    exp_t e;
    string t;
    logic [20:0] obs;
    e = sb.pop_front();
    t = tag_q.pop_front();
    obs = {bus.state, bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.illegal,
           bus.NPCOp, bus.M1Sel, bus.M2Sel, bus.M3Sel, bus.EXTOp, bus.ALUOp};
    total++;
    assert ((obs & e.mask) === (e.vec & e.mask)) passed++;
    else begin
      fails++;
      $error("FAIL %s ctrl observed=%h expected=%h", t, obs & e.mask, e.vec & e.mask);
    end
    total++;
    assert (bus.instr_cnt === e.cnt) passed++;
    else begin
      fails++;
      $error("FAIL %s instr_cnt observed=%0d expected=%0d", t, bus.instr_cnt, e.cnt);
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic rdy, input logic [2:0] st, input logic [4:0] en, input logic [12:0] sel);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    bus.op = o;
    bus.funct = f;
    bus.dm_ready = rdy;
    e.vec  = {st, en, sel};
    e.mask = (rst || st == S_F) ? 21'h1FE000 : 21'h1FFFFF;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    tag_q.push_back(tag);
    if (rst) exp_cnt = 32'd0;
    else if (en[4]) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    check();
  endtask

  task automatic run_alu(input string tag, input logic [5:0] o, input logic [5:0] f, input logic [12:0] sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_F, EN_IR, sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_D, EN_0, sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_E, EN_0, sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_WB, EN_WB, sel);
  endtask

  task automatic run_br(input string tag, input logic [5:0] o, input logic [5:0] f, input logic [12:0] sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_F, EN_IR, sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_D, EN_0, sel);
    cyc(tag, 1'b0, o, f, 1'b1, S_E, EN_PC, sel);
  endtask

  task automatic run_lw(input int stalls);
    cyc("lw", 1'b0, 6'b100011, 6'd0, 1'b0, S_F, EN_IR, SL_LW);
    cyc("lw", 1'b0, 6'b100011, 6'd0, 1'b0, S_D, EN_0, SL_LW);
    cyc("lw", 1'b0, 6'b100011, 6'd0, 1'b0, S_E, EN_0, SL_LW);
    for (int i = 0; i < stalls; i++) cyc("lw_stall", 1'b0, 6'b100011, 6'd0, 1'b0, S_MR, EN_0, SL_LW);
    cyc("lw_rdy", 1'b0, 6'b100011, 6'd0, 1'b1, S_MR, EN_0, SL_LW);
    cyc("lw_wb", 1'b0, 6'b100011, 6'd0, 1'b0, S_WB, EN_WB, SL_LW);
  endtask

  task automatic run_sw(input int stalls);
    cyc("sw", 1'b0, 6'b101011, 6'd0, 1'b0, S_F, EN_IR, SL_SW);
    cyc("sw", 1'b0, 6'b101011, 6'd0, 1'b0, S_D, EN_0, SL_SW);
    cyc("sw", 1'b0, 6'b101011, 6'd0, 1'b0, S_E, EN_0, SL_SW);
    for (int i = 0; i < stalls; i++) cyc("sw_stall", 1'b0, 6'b101011, 6'd0, 1'b0, S_MW, EN_DM, SL_SW);
    cyc("sw_rdy", 1'b0, 6'b101011, 6'd0, 1'b1, S_MW, EN_DMPC, SL_SW);
  endtask

  initial begin
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.dm_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    cyc("reset", 1'b1, 6'd0, 6'd0, 1'b1, S_F, EN_0, SL_NOP);

    run_alu("addu", 6'b000000, 6'b100001, SL_ADDU);
    run_alu("subu", 6'b000000, 6'b100011, SL_SUBU);
    run_alu("sltu", 6'b000000, 6'b101011, SL_SLTU);
    run_alu("ori", 6'b001101, 6'd0, SL_ORI);
    run_alu("lui", 6'b001111, 6'd0, SL_LUI);
    run_lw(2);
    run_sw(0);
    run_sw(1);
    run_br("beq", 6'b000100, 6'd0, SL_BEQ);
    run_br("jr", 6'b000000, 6'b001000, SL_JR);

    cyc("jal", 1'b0, 6'b000011, 6'd0, 1'b1, S_F, EN_IR, SL_JAL);
    cyc("jal", 1'b0, 6'b000011, 6'd0, 1'b1, S_D, EN_0, SL_JAL);
    cyc("jal_wb", 1'b0, 6'b000011, 6'd0, 1'b1, S_WB, EN_WB, SL_JAL);

    cyc("ill_op", 1'b0, 6'b111111, 6'd0, 1'b1, S_F, EN_IR, SL_NOP);
    cyc("ill_op", 1'b0, 6'b111111, 6'd0, 1'b1, S_D, EN_ILL, SL_NOP);
    cyc("ill_fn", 1'b0, 6'b000000, 6'b000000, 1'b0, S_F, EN_IR, SL_NOP);
    cyc("ill_fn", 1'b0, 6'b000000, 6'b000000, 1'b0, S_D, EN_ILL, SL_NOP);

    // Reset lands in the middle of a store stall
    cyc("rst_sw", 1'b0, 6'b101011, 6'd0, 1'b0, S_F, EN_IR, SL_SW);
    cyc("rst_sw", 1'b0, 6'b101011, 6'd0, 1'b0, S_D, EN_0, SL_SW);
    cyc("rst_sw", 1'b0, 6'b101011, 6'd0, 1'b0, S_E, EN_0, SL_SW);
    cyc("rst_sw_stall", 1'b0, 6'b101011, 6'd0, 1'b0, S_MW, EN_DM, SL_SW);
    cyc("rst_hit", 1'b1, 6'b101011, 6'd0, 1'b0, S_MW, EN_0, SL_SW);
    cyc("rst_held", 1'b1, 6'b101011, 6'd0, 1'b1, S_F, EN_0, SL_SW);
    run_alu("post_rst", 6'b000000, 6'b100001, SL_ADDU);
    cyc("final", 1'b0, 6'b000000, 6'b100001, 1'b0, S_F, EN_IR, SL_ADDU);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
